// File: rtl/pipemdctl_pkg.sv
// pipemd_pkg: shared op codes, FSM states, sizing constants and magnitude helper for the MD unit
package pipemd_pkg;
   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CW    = $clog2(ITER);
   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
endpackage

// File: rtl/pipemdctl_if.sv
// pipemdctl_if: EXE-stage request and MD unit response bundle
interface pipemdctl_if;
   import pipemd_pkg::*;
   logic [3:0]       emdop;
   logic [WIDTH-1:0] ea;
   logic [WIDTH-1:0] eb;
   logic             ecancel;
   logic             efreeze;
   logic             mdu_stall;
   logic             mdu_busy;
   logic [WIDTH-1:0] emdval;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output emdop, ea, eb, ecancel, efreeze, input mdu_stall, mdu_busy, emdval, hi, lo);
   modport slave  (input emdop, ea, eb, ecancel, efreeze, output mdu_stall, mdu_busy, emdval, hi, lo);
endinterface

// File: rtl/pipemdctl_core.sv
// md_core: iterative shift-add multiplier / restoring divider with sign fix-up
module md_core import pipemd_pkg::*; (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               fix_i,
   input  logic [3:0]         op_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] res_o
);
   logic [2*WIDTH-1:0] acc_q, nxt, fixd;
   logic [WIDTH-1:0]   a_q, b_q, trial;
   logic [WIDTH:0]     sum, rem_sh;
   logic               div_q, sgn_q, sa_q, sb_q, neg, ge, s;
   // one iteration step and the final sign correction, both from the current accumulator
   always_comb begin
      s = op_i == MD_MULT || op_i == MD_DIV;
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
      ge = rem_sh >= {1'b0, b_q};
      trial = rem_sh[WIDTH-1:0] - b_q;
      nxt = div_q ? {ge ? trial : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
      neg = sgn_q && (sa_q ^ sb_q);
      fixd = !div_q ? (neg ? -acc_q : acc_q)
           : b_q == '0 ? {a_q, {WIDTH{1'b1}}}
           : {sgn_q && sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH],
              neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
      res_o = fix_i ? fixd : acc_q;
   end
   // latch magnitudes and signs on load, then advance one bit per step
   always_ff @(posedge clk)
      if (rst) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         sgn_q <= 1'b0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
      end else if (load_i) begin
         acc_q <= {{WIDTH{1'b0}}, s ? mag32(a_i) : a_i};
         b_q   <= s ? mag32(b_i) : b_i;
         a_q   <= a_i;
         div_q <= op_i == MD_DIV || op_i == MD_DIVU;
         sgn_q <= s;
         sa_q  <= a_i[WIDTH-1];
         sb_q  <= b_i[WIDTH-1];
      end else if (step_i)
         acc_q <= nxt;
endmodule

// File: rtl/pipemdctl.sv
// pipemdctl: multiply/divide sequencer owning HI/LO, stall and move-from logic
module pipemdctl import pipemd_pkg::*; (
   input logic        clock,
   input logic        reset,
   pipemdctl_if.slave bus
);
   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [3:0]         op;
   logic               start, any, load;
   logic [2*WIDTH-1:0] res;
   // effective op decode and the combinational pipeline-facing outputs
   always_comb begin
      op = bus.ecancel ? MD_NONE : bus.emdop;
      start = op >= MD_MULT && op <= MD_DIVU;
      any = op >= MD_MULT && op <= MD_MTLO;
      load = state_q == IDLE && start && !bus.efreeze;
      bus.mdu_busy = state_q != IDLE;
      bus.mdu_stall = bus.mdu_busy && any;
      bus.emdval = bus.mdu_busy ? '0 : op == MD_MFHI ? hi_q : op == MD_MFLO ? lo_q : '0;
      bus.hi = hi_q;
      bus.lo = lo_q;
   end
   md_core u_core (
      .clk    (clock),
      .rst    (reset),
      .load_i (load),
      .step_i (state_q == CALC),
      .fix_i  (state_q == FIX),
      .op_i   (op),
      .a_i    (bus.ea),
      .b_i    (bus.eb),
      .res_o  (res)
   );
   // sequencer: accept in IDLE, iterate ITER times, commit HI/LO in FIX
   always_ff @(posedge clock)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else
         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q <= CALC;
                  cnt_q   <= '0;
               end
               if (!bus.efreeze && op == MD_MTHI) hi_q <= bus.ea;
               if (!bus.efreeze && op == MD_MTLO) lo_q <= bus.ea;
            end
            CALC: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
            end
            default: begin
               {hi_q, lo_q} <= res;
               state_q      <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_pipemdctl.sv
// tb_pipemdctl: directed stimulus with queued expectations checked by a negedge monitor
module tb_pipemdctl;
   import pipemd_pkg::*;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } res_t;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_busy = 1'b0;
   logic        last_stall;
   logic [31:0] last_emd;
   res_t        rq[$];
   logic [31:0] eq[$];
   res_t        r;
   logic [31:0] e;
   pipemdctl_if bus();
   pipemdctl dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.emdop = op;
      bus.ea = a;
      bus.eb = b;
      #1;
      last_stall = bus.mdu_stall;
      last_emd = bus.emdval;
      @(posedge clock);
      #1;
   endtask
   task automatic run_md(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int n;
      n = cyc;
      rq.push_back('{ehi, elo, n + 34});
      step(op, a, b);
      chk({nm, "_busy"}, 64'(bus.mdu_busy), 64'd1);
      for (int i = 0; i < 100 && bus.mdu_busy; i++) step(MD_NONE, 0, 0);
      chk({nm, "_idle_cyc"}, 64'(cyc), 64'(n + 34));
   endtask
   // monitor: a busy->idle transition delivers a result, an unstalled move-from delivers emdval
   always @(negedge clock) begin
      if (prev_busy && !bus.mdu_busy) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected hi %h lo %h", bus.hi, bus.lo);
         end else begin
            r = rq.pop_front();
            chk("res_hi", 64'(bus.hi), 64'(r.hi));
            chk("res_lo", 64'(bus.lo), 64'(r.lo));
            chk("res_cyc", 64'(cyc), 64'(r.cyc));
         end
      end
      if ((bus.emdop == MD_MFHI || bus.emdop == MD_MFLO) && !bus.ecancel && !bus.mdu_stall) begin
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL emd_unexpected emdval %h", bus.emdval);
         end else begin
            e = eq.pop_front();
            chk("emdval", 64'(bus.emdval), 64'(e));
         end
      end
      prev_busy = bus.mdu_busy;
   end
   initial begin
      int n, k, acc;
      bus.emdop = MD_NONE;
      bus.ea = 0;
      bus.eb = 0;
      bus.ecancel = 1'b0;
      bus.efreeze = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_busy", 64'(bus.mdu_busy), 64'd0);
      chk("rst_stall", 64'(bus.mdu_stall), 64'd0);
      chk("rst_emdval", 64'(bus.emdval), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      n = cyc;
      rq.push_back('{32'h0, 32'h0, n + 11});
      step(MD_MULT, 32'd5, 32'd7);
      repeat (9) step(MD_NONE, 0, 0);
      chk("rst_mid_cyc", 64'(cyc), 64'(n + 10));
      reset = 1'b1;
      step(MD_NONE, 0, 0);
      reset = 1'b0;
      chk("rst_mid_busy", 64'(bus.mdu_busy), 64'd0);
      repeat (30) step(MD_NONE, 0, 0);
      chk("rst_mid_hi", 64'(bus.hi), 64'd0);
      chk("rst_mid_lo", 64'(bus.lo), 64'd0);
      run_md("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_md("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
      run_md("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_md("divu0", MD_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
      run_md("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
      bus.ecancel = 1'b1;
      step(MD_MULT, 32'd3, 32'd3);
      bus.ecancel = 1'b0;
      chk("cancel_busy", 64'(bus.mdu_busy), 64'd0);
      bus.efreeze = 1'b1;
      step(MD_MULT, 32'd3, 32'd3);
      bus.efreeze = 1'b0;
      chk("freeze_busy", 64'(bus.mdu_busy), 64'd0);
      n = cyc;
      rq.push_back('{32'h0, 32'd42, n + 34});
      eq.push_back(32'd42);
      step(MD_MULT, 32'd6, 32'd7);
      step(MD_NONE, 0, 0);
      chk("alu_stall", 64'(last_stall), 64'd0);
      acc = 0;
      for (k = 0; k < 100; k++) begin
         acc = cyc;
         step(MD_MFLO, 0, 0);
         if (k == 0) chk("mflo_busy_emd", 64'(last_emd), 64'd0);
         if (!last_stall) break;
      end
      chk("mflo_stalls", 64'(k), 64'd32);
      chk("mflo_acc_cyc", 64'(acc), 64'(n + 34));
      n = cyc;
      rq.push_back('{32'd2, 32'd14, n + 34});
      rq.push_back('{32'd1, 32'd0, n + 68});
      step(MD_DIVU, 32'd100, 32'd7);
      for (k = 0; k < 100; k++) begin
         acc = cyc;
         step(MD_MULTU, 32'h00010000, 32'h00010000);
         if (!last_stall) break;
      end
      chk("b2b_stalls", 64'(k), 64'd33);
      chk("b2b_acc_cyc", 64'(acc), 64'(n + 34));
      for (int i = 0; i < 100 && bus.mdu_busy; i++) step(MD_NONE, 0, 0);
      chk("b2b_idle_cyc", 64'(cyc), 64'(n + 68));
      bus.efreeze = 1'b1;
      step(MD_MTHI, 32'h12345678, 0);
      bus.efreeze = 1'b0;
      chk("mthi_frz_hi", 64'(bus.hi), 64'd1);
      step(MD_MTHI, 32'h12345678, 0);
      chk("mthi_hi", 64'(bus.hi), 64'h12345678);
      chk("mthi_lo", 64'(bus.lo), 64'd0);
      eq.push_back(32'h12345678);
      step(MD_MFHI, 0, 0);
      step(MD_MTLO, 32'hCAFEF00D, 0);
      chk("mtlo_lo", 64'(bus.lo), 64'hCAFEF00D);
      chk("mtlo_hi", 64'(bus.hi), 64'h12345678);
      step(MD_NONE, 0, 0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      chk("eq_empty", 64'(eq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
